// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared FIFO constants, depth helper and parameter-legality check used by
// param_sync_fifo, its interface and its storage sub-module.
// No ports (package).
// -----------------------------------------------------------------------------
package fifo_pkg;

    // Default geometry of the FIFOs in this codebase.
    localparam int FIFO_DEF_BITS      = 8;
    localparam int FIFO_DEF_SIZE      = 4;
    localparam int FIFO_DEF_AEMPTY_TH = 2;
    localparam int FIFO_DEF_FWFT      = 0;

    // Level flags, all derived from the registered word count.
    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_flags_t;

    // DEPTH = 2^SIZE.
    function automatic int fifo_depth(input int size);
        return 1 << size;
    endfunction

    // True when a parameter set describes a buildable FIFO. The upper bound on
    // size keeps the depth computation inside a 32-bit int.
    function automatic bit fifo_params_legal(input int bits,
                                             input int size,
                                             input int afull_th,
                                             input int aempty_th,
                                             input int fwft);
        int depth;
        depth = fifo_depth(size);
        return (bits >= 1) && (size >= 1) && (size <= 30) &&
               (afull_th >= 1) && (afull_th <= depth) &&
               (aempty_th >= 0) && (aempty_th <= depth - 1) &&
               ((fwft == 0) || (fwft == 1));
    endfunction

endpackage

// File: rtl/param_sync_fifo_if.sv
// -----------------------------------------------------------------------------
// param_sync_fifo_if
// Request/status bundle between a FIFO user (master) and param_sync_fifo
// (slave).
//   master drives : CLEAR, WE, DATAIN, RE
//   slave drives  : Q, FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY, COUNT,
//                   OVERFLOW, UNDERFLOW
// Handshake: WE acts as write-valid with !FULL as its ready, RE acts as
// read-valid with !EMPTY as its ready; a transfer happens on a rising clock
// edge where valid and ready are both high and CLEAR is low. A request made
// while not ready is dropped (not held) and recorded in the sticky
// OVERFLOW/UNDERFLOW status.
// -----------------------------------------------------------------------------
interface param_sync_fifo_if #(
    parameter int BITS = fifo_pkg::FIFO_DEF_BITS,
    parameter int SIZE = fifo_pkg::FIFO_DEF_SIZE
);
    logic            CLEAR;
    logic            WE;
    logic [BITS-1:0] DATAIN;
    logic            RE;
    logic [BITS-1:0] Q;
    logic            FULL;
    logic            EMPTY;
    logic            ALMOST_FULL;
    logic            ALMOST_EMPTY;
    logic [SIZE:0]   COUNT;
    logic            OVERFLOW;
    logic            UNDERFLOW;

    modport master (
        output CLEAR, WE, DATAIN, RE,
        input  Q, FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY, COUNT,
               OVERFLOW, UNDERFLOW
    );

    modport slave (
        input  CLEAR, WE, DATAIN, RE,
        output Q, FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY, COUNT,
               OVERFLOW, UNDERFLOW
    );
endinterface

// File: rtl/fifo_ram.sv
// -----------------------------------------------------------------------------
// fifo_ram
// BITS x 2^SIZE storage: one synchronous write port, one asynchronous read
// port. Contents are never reset.
//   clk   in  write clock
//   we    in  write enable
//   waddr in  write address
//   wdata in  write data
//   raddr in  read address
//   rdata out read data (combinational from raddr)
// -----------------------------------------------------------------------------
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int BITS = FIFO_DEF_BITS,
    parameter int SIZE = FIFO_DEF_SIZE
) (
    input  logic            clk,
    input  logic            we,
    input  logic [SIZE-1:0] waddr,
    input  logic [BITS-1:0] wdata,
    input  logic [SIZE-1:0] raddr,
    output logic [BITS-1:0] rdata
);
    localparam int DEPTH = fifo_depth(SIZE);

    logic [BITS-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/param_sync_fifo.sv
// -----------------------------------------------------------------------------
// param_sync_fifo
// Single-clock FIFO with level flags, sticky overflow/underflow status and a
// selectable read mode (registered Q or first-word-fall-through).
//   CLK    in  clock, all state changes on the rising edge
//   RESET  in  asynchronous active-low reset
//   bus    slave side of param_sync_fifo_if (CLEAR, WE, DATAIN, RE in;
//          Q, FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY, COUNT, OVERFLOW,
//          UNDERFLOW out)
// -----------------------------------------------------------------------------
module param_sync_fifo
    import fifo_pkg::*;
#(
    parameter int BITS      = FIFO_DEF_BITS,
    parameter int SIZE      = FIFO_DEF_SIZE,
    parameter int AFULL_TH  = fifo_depth(SIZE) - 2,
    parameter int AEMPTY_TH = FIFO_DEF_AEMPTY_TH,
    parameter int FWFT      = FIFO_DEF_FWFT
) (
    input  logic              CLK,
    input  logic              RESET,
    param_sync_fifo_if.slave  bus
);
    localparam int DEPTH = fifo_depth(SIZE);

    if (!fifo_params_legal(BITS, SIZE, AFULL_TH, AEMPTY_TH, FWFT)) begin : g_illegal_params
        $error("param_sync_fifo: illegal parameter set");
    end

    localparam logic [SIZE:0] FULL_LVL = (SIZE+1)'(DEPTH);
    localparam logic [SIZE:0] AF_LVL   = (SIZE+1)'(AFULL_TH);
    localparam logic [SIZE:0] AE_LVL   = (SIZE+1)'(AEMPTY_TH);
    localparam logic [SIZE:0] ONE      = (SIZE+1)'(1);

    // Pointers carry one extra bit so they wrap modulo 2*DEPTH; the low SIZE
    // bits address the RAM.
    logic [SIZE:0]   wptr;
    logic [SIZE:0]   rptr;
    logic [SIZE:0]   count;
    logic            overflow;
    logic            underflow;
    logic [BITS-1:0] q_reg;
    logic [BITS-1:0] ram_rdata;
    logic            wr_ok;
    logic            rd_ok;
    fifo_flags_t     flags;

    // Flags come only from the registered count: a write or read in the
    // current cycle is not visible until after the edge.
    always_comb begin
        flags              = '0;
        flags.full         = (count == FULL_LVL);
        flags.empty        = (count == '0);
        flags.almost_full  = (count >= AF_LVL);
        flags.almost_empty = (count <= AE_LVL);
    end

    assign wr_ok = bus.WE && !flags.full  && !bus.CLEAR;
    assign rd_ok = bus.RE && !flags.empty && !bus.CLEAR;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            q_reg     <= '0;
        end else if (bus.CLEAR) begin
            // Flush wins over any request in the same cycle; RAM keeps its data.
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            q_reg     <= '0;
        end else begin
            if (wr_ok) begin
                wptr <= wptr + ONE;
            end
            if (rd_ok) begin
                rptr  <= rptr + ONE;
                q_reg <= ram_rdata;
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + ONE;
                2'b01:   count <= count - ONE;
                default: count <= count;
            endcase
            overflow  <= overflow  | (bus.WE & flags.full);
            underflow <= underflow | (bus.RE & flags.empty);
        end
    end

    fifo_ram #(
        .BITS (BITS),
        .SIZE (SIZE)
    ) u_ram (
        .clk   (CLK),
        .we    (wr_ok),
        .waddr (wptr[SIZE-1:0]),
        .wdata (bus.DATAIN),
        .raddr (rptr[SIZE-1:0]),
        .rdata (ram_rdata)
    );

    // FWFT shows the head word straight from the RAM read port; it is
    // meaningless while EMPTY is high.
    assign bus.Q            = (FWFT != 0) ? ram_rdata : q_reg;
    assign bus.FULL         = flags.full;
    assign bus.EMPTY        = flags.empty;
    assign bus.ALMOST_FULL  = flags.almost_full;
    assign bus.ALMOST_EMPTY = flags.almost_empty;
    assign bus.COUNT        = count;
    assign bus.OVERFLOW     = overflow;
    assign bus.UNDERFLOW    = underflow;
endmodule

// File: tb/tb_param_sync_fifo.sv
// -----------------------------------------------------------------------------
// tb_param_sync_fifo
// Drives a registered-read FIFO (dut0) and an FWFT FIFO (dut1) with identical
// stimulus and compares both against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_param_sync_fifo;
    localparam int BITS      = 8;
    localparam int SIZE      = 2;
    localparam int DEPTH     = 4;
    localparam int AFULL_TH  = 3;
    localparam int AEMPTY_TH = 1;

    // ---------------- clock / reset ----------------
    logic CLK;
    logic RESET;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    param_sync_fifo_if #(.BITS(BITS), .SIZE(SIZE)) bus0 ();
    param_sync_fifo_if #(.BITS(BITS), .SIZE(SIZE)) bus1 ();

    param_sync_fifo #(
        .BITS(BITS), .SIZE(SIZE), .AFULL_TH(AFULL_TH), .AEMPTY_TH(AEMPTY_TH), .FWFT(0)
    ) dut0 (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus0)
    );

    param_sync_fifo #(
        .BITS(BITS), .SIZE(SIZE), .AFULL_TH(AFULL_TH), .AEMPTY_TH(AEMPTY_TH), .FWFT(1)
    ) dut1 (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus1)
    );

    // ---------------- reference model / scoreboard ----------------
    int              n_cmp = 0;
    int              n_err = 0;
    logic [BITS-1:0] exp_q[$];
    logic            m_ovf;
    logic            m_unf;
    logic [BITS-1:0] m_qreg;
    logic            d_clr;
    logic            d_we;
    logic            d_re;
    logic [BITS-1:0] d_din;

    task automatic model_reset();
        exp_q.delete();
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        m_qreg = '0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic clr, input logic we, input logic re,
                         input logic [BITS-1:0] din);
        d_clr = clr;
        d_we  = we;
        d_re  = re;
        d_din = din;
        bus0.CLEAR = clr; bus0.WE = we; bus0.RE = re; bus0.DATAIN = din;
        bus1.CLEAR = clr; bus1.WE = we; bus1.RE = re; bus1.DATAIN = din;
    endtask

    // One clock: the model applies the FIFO rules to the state before the
    // edge, then outputs are sampled 1 time unit after it.
    task automatic tick();
        bit was_full;
        bit was_empty;
        @(posedge CLK);
        if (d_clr) begin
            model_reset();
        end else begin
            was_full  = (exp_q.size() == DEPTH);
            was_empty = (exp_q.size() == 0);
            if (d_re) begin
                if (was_empty) m_unf = 1'b1;
                else           m_qreg = exp_q.pop_front();
            end
            if (d_we) begin
                if (was_full) m_ovf = 1'b1;
                else          exp_q.push_back(d_din);
            end
        end
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        RESET = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0);
        model_reset();
        #2;
        n_cmp++; if (bus0.COUNT !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", bus0.COUNT); end
        n_cmp++; if (bus0.EMPTY !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b want 1", bus0.EMPTY); end
        n_cmp++; if (bus0.ALMOST_EMPTY !== 1'b1) begin n_err++; $display("FAIL reset_aempty: got %b want 1", bus0.ALMOST_EMPTY); end
        n_cmp++; if (bus0.FULL !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b want 0", bus0.FULL); end
        n_cmp++; if (bus0.ALMOST_FULL !== 1'b0) begin n_err++; $display("FAIL reset_afull: got %b want 0", bus0.ALMOST_FULL); end
        n_cmp++; if (bus0.OVERFLOW !== 1'b0 || bus0.UNDERFLOW !== 1'b0) begin n_err++; $display("FAIL reset_sticky: got ovf=%b unf=%b want 0/0", bus0.OVERFLOW, bus0.UNDERFLOW); end
        n_cmp++; if (bus0.Q !== 8'h00) begin n_err++; $display("FAIL reset_q: got %h want 00", bus0.Q); end
        n_cmp++; if (bus1.COUNT !== 3'd0 || bus1.EMPTY !== 1'b1) begin n_err++; $display("FAIL reset_fwft: got count=%0d empty=%b want 0/1", bus1.COUNT, bus1.EMPTY); end
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b1;
    endtask

    task automatic test_fill();
        logic [BITS-1:0] data [5];
        int n;
        data = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 1'b0, data[i]);
            tick();
            n = i + 1;
            n_cmp++; if (bus0.COUNT !== 3'(n)) begin n_err++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, bus0.COUNT, n); end
            n_cmp++; if (bus0.ALMOST_EMPTY !== (n <= AEMPTY_TH)) begin n_err++; $display("FAIL fill_aempty[%0d]: got %b want %b", i, bus0.ALMOST_EMPTY, (n <= AEMPTY_TH)); end
            n_cmp++; if (bus0.ALMOST_FULL !== (n >= AFULL_TH)) begin n_err++; $display("FAIL fill_afull[%0d]: got %b want %b", i, bus0.ALMOST_FULL, (n >= AFULL_TH)); end
            n_cmp++; if (bus0.FULL !== (n == DEPTH)) begin n_err++; $display("FAIL fill_full[%0d]: got %b want %b", i, bus0.FULL, (n == DEPTH)); end
            n_cmp++; if (bus1.Q !== 8'h11) begin n_err++; $display("FAIL fill_fwft_head[%0d]: got %h want 11", i, bus1.Q); end
        end
        drive(1'b0, 1'b1, 1'b0, data[4]);
        tick();
        drive(1'b0, 1'b0, 1'b0, '0);
        n_cmp++; if (bus0.OVERFLOW !== 1'b1) begin n_err++; $display("FAIL fill_overflow: got %b want 1", bus0.OVERFLOW); end
        n_cmp++; if (bus0.COUNT !== 3'd4 || bus0.FULL !== 1'b1) begin n_err++; $display("FAIL fill_reject: got count=%0d full=%b want 4/1", bus0.COUNT, bus0.FULL); end
    endtask

    task automatic test_drain();
        logic [BITS-1:0] data [4];
        data = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 1'b1, '0);
            tick();
            n_cmp++; if (bus0.Q !== data[i]) begin n_err++; $display("FAIL drain_q[%0d]: got %h want %h", i, bus0.Q, data[i]); end
            n_cmp++; if (bus0.COUNT !== 3'(3 - i)) begin n_err++; $display("FAIL drain_count[%0d]: got %0d want %0d", i, bus0.COUNT, 3 - i); end
            if (i < 3) begin
                n_cmp++; if (bus1.Q !== data[i+1]) begin n_err++; $display("FAIL drain_fwft_head[%0d]: got %h want %h", i, bus1.Q, data[i+1]); end
            end
        end
        n_cmp++; if (bus0.EMPTY !== 1'b1) begin n_err++; $display("FAIL drain_empty: got %b want 1", bus0.EMPTY); end
        drive(1'b0, 1'b0, 1'b1, '0);
        tick();
        drive(1'b0, 1'b0, 1'b0, '0);
        n_cmp++; if (bus0.UNDERFLOW !== 1'b1 || bus1.UNDERFLOW !== 1'b1) begin n_err++; $display("FAIL drain_underflow: got %b/%b want 1/1", bus0.UNDERFLOW, bus1.UNDERFLOW); end
        n_cmp++; if (bus0.Q !== 8'h44) begin n_err++; $display("FAIL drain_q_hold: got %h want 44", bus0.Q); end
        n_cmp++; if (bus0.OVERFLOW !== 1'b1) begin n_err++; $display("FAIL drain_ovf_sticky: got %b want 1", bus0.OVERFLOW); end
    endtask

    task automatic test_fwft();
        drive(1'b1, 1'b0, 1'b0, '0);
        tick();
        drive(1'b0, 1'b1, 1'b0, 8'hA5);
        tick();
        drive(1'b0, 1'b0, 1'b0, '0);
        n_cmp++; if (bus1.EMPTY !== 1'b0 || bus1.Q !== 8'hA5) begin n_err++; $display("FAIL fwft_show: got empty=%b q=%h want 0/a5", bus1.EMPTY, bus1.Q); end
        n_cmp++; if (bus0.Q !== 8'h00) begin n_err++; $display("FAIL fwft_regq_idle: got %h want 00", bus0.Q); end
        drive(1'b0, 1'b0, 1'b1, '0);
        tick();
        drive(1'b0, 1'b0, 1'b0, '0);
        n_cmp++; if (bus1.EMPTY !== 1'b1) begin n_err++; $display("FAIL fwft_pop: got empty=%b want 1", bus1.EMPTY); end
        n_cmp++; if (bus0.Q !== 8'hA5) begin n_err++; $display("FAIL fwft_regq_pop: got %h want a5", bus0.Q); end
    endtask

    task automatic test_simultaneous();
        drive(1'b1, 1'b0, 1'b0, '0);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 1'b0, BITS'($urandom));
            tick();
        end
        drive(1'b0, 1'b1, 1'b1, BITS'($urandom));
        tick();
        n_cmp++; if (bus0.COUNT !== 3'd3 || bus0.OVERFLOW !== 1'b1) begin n_err++; $display("FAIL simul_full: got count=%0d ovf=%b want 3/1", bus0.COUNT, bus0.OVERFLOW); end
        n_cmp++; if (bus0.Q !== m_qreg) begin n_err++; $display("FAIL simul_full_q: got %h want %h", bus0.Q, m_qreg); end
        drive(1'b0, 1'b0, 1'b1, '0);
        tick();
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b1, 1'b1, BITS'($urandom));
            tick();
            n_cmp++; if (bus0.COUNT !== 3'd2) begin n_err++; $display("FAIL simul_count[%0d]: got %0d want 2", i, bus0.COUNT); end
            n_cmp++; if (bus0.Q !== m_qreg) begin n_err++; $display("FAIL simul_q[%0d]: got %h want %h", i, bus0.Q, m_qreg); end
            n_cmp++; if (bus1.Q !== exp_q[0]) begin n_err++; $display("FAIL simul_fwft_q[%0d]: got %h want %h", i, bus1.Q, exp_q[0]); end
        end
        drive(1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic test_clear();
        drive(1'b0, 1'b1, 1'b0, 8'h5A);
        tick();
        n_cmp++; if (bus0.COUNT !== 3'd3 || bus0.OVERFLOW !== 1'b1) begin n_err++; $display("FAIL clear_pre: got count=%0d ovf=%b want 3/1", bus0.COUNT, bus0.OVERFLOW); end
        drive(1'b1, 1'b1, 1'b0, 8'hC3);
        tick();
        drive(1'b0, 1'b0, 1'b0, '0);
        n_cmp++; if (bus0.COUNT !== 3'd0 || bus0.EMPTY !== 1'b1) begin n_err++; $display("FAIL clear_level: got count=%0d empty=%b want 0/1", bus0.COUNT, bus0.EMPTY); end
        n_cmp++; if (bus0.OVERFLOW !== 1'b0) begin n_err++; $display("FAIL clear_ovf: got %b want 0", bus0.OVERFLOW); end
        n_cmp++; if (bus0.Q !== 8'h00) begin n_err++; $display("FAIL clear_q: got %h want 00", bus0.Q); end
        tick();
        n_cmp++; if (bus0.COUNT !== 3'd0) begin n_err++; $display("FAIL clear_discard: got count=%0d want 0", bus0.COUNT); end
    endtask

    task automatic test_reset_mid();
        drive(1'b0, 1'b0, 1'b1, '0);
        tick();
        drive(1'b0, 1'b1, 1'b0, 8'h31);
        tick();
        drive(1'b0, 1'b1, 1'b0, 8'h32);
        tick();
        n_cmp++; if (bus0.COUNT !== 3'd2 || bus0.UNDERFLOW !== 1'b1) begin n_err++; $display("FAIL rmid_pre: got count=%0d unf=%b want 2/1", bus0.COUNT, bus0.UNDERFLOW); end
        drive(1'b0, 1'b1, 1'b0, 8'h33);
        #2;
        RESET = 1'b0;
        model_reset();
        #1;
        n_cmp++; if (bus0.COUNT !== 3'd0 || bus0.EMPTY !== 1'b1 || bus0.ALMOST_EMPTY !== 1'b1) begin n_err++; $display("FAIL rmid_level: got count=%0d empty=%b aempty=%b want 0/1/1", bus0.COUNT, bus0.EMPTY, bus0.ALMOST_EMPTY); end
        n_cmp++; if (bus0.FULL !== 1'b0 || bus0.ALMOST_FULL !== 1'b0) begin n_err++; $display("FAIL rmid_full: got full=%b afull=%b want 0/0", bus0.FULL, bus0.ALMOST_FULL); end
        n_cmp++; if (bus0.OVERFLOW !== 1'b0 || bus0.UNDERFLOW !== 1'b0) begin n_err++; $display("FAIL rmid_sticky: got ovf=%b unf=%b want 0/0", bus0.OVERFLOW, bus0.UNDERFLOW); end
        n_cmp++; if (bus0.Q !== 8'h00) begin n_err++; $display("FAIL rmid_q: got %h want 00", bus0.Q); end
        drive(1'b0, 1'b0, 1'b0, '0);
        @(posedge CLK);
        #1;
        RESET = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 8'h77);
        tick();
        n_cmp++; if (bus1.COUNT !== 3'd1 || bus1.Q !== 8'h77) begin n_err++; $display("FAIL rmid_fwft: got count=%0d q=%h want 1/77", bus1.COUNT, bus1.Q); end
        drive(1'b0, 1'b0, 1'b1, '0);
        tick();
        drive(1'b0, 1'b0, 1'b0, '0);
        n_cmp++; if (bus0.Q !== 8'h77 || bus0.COUNT !== 3'd0) begin n_err++; $display("FAIL rmid_read: got q=%h count=%0d want 77/0", bus0.Q, bus0.COUNT); end
    endtask

    task automatic test_random();
        int n;
        int wbias;
        logic [SIZE:0] exp_cnt;
        drive(1'b1, 1'b0, 1'b0, '0);
        tick();
        for (int i = 0; i < 400; i++) begin
            // Alternate fill-heavy and drain-heavy phases so both ends get hit.
            wbias = ((i / 50) % 2 == 0) ? 3 : 1;
            drive(($urandom_range(0, 59) == 0),
                  ($urandom_range(0, 3) < wbias),
                  ($urandom_range(0, 3) >= wbias),
                  BITS'($urandom));
            tick();
            n = exp_q.size();
            exp_cnt = (SIZE+1)'(n);
            n_cmp++; if (bus0.COUNT !== exp_cnt || bus1.COUNT !== exp_cnt) begin n_err++; $display("FAIL rand_count[%0d]: got %0d/%0d want %0d", i, bus0.COUNT, bus1.COUNT, n); end
            n_cmp++; if (bus0.EMPTY !== (n == 0) || bus0.FULL !== (n == DEPTH)) begin n_err++; $display("FAIL rand_ef[%0d]: got e=%b f=%b want e=%b f=%b", i, bus0.EMPTY, bus0.FULL, (n == 0), (n == DEPTH)); end
            n_cmp++; if (bus0.ALMOST_EMPTY !== (n <= AEMPTY_TH) || bus0.ALMOST_FULL !== (n >= AFULL_TH)) begin n_err++; $display("FAIL rand_almost[%0d]: got ae=%b af=%b want ae=%b af=%b", i, bus0.ALMOST_EMPTY, bus0.ALMOST_FULL, (n <= AEMPTY_TH), (n >= AFULL_TH)); end
            n_cmp++; if (bus0.OVERFLOW !== m_ovf || bus0.UNDERFLOW !== m_unf) begin n_err++; $display("FAIL rand_sticky[%0d]: got ovf=%b unf=%b want ovf=%b unf=%b", i, bus0.OVERFLOW, bus0.UNDERFLOW, m_ovf, m_unf); end
            n_cmp++; if (bus0.Q !== m_qreg) begin n_err++; $display("FAIL rand_q[%0d]: got %h want %h", i, bus0.Q, m_qreg); end
            if (n > 0) begin
                n_cmp++; if (bus1.Q !== exp_q[0]) begin n_err++; $display("FAIL rand_fwft_q[%0d]: got %h want %h", i, bus1.Q, exp_q[0]); end
            end
        end
        drive(1'b0, 1'b0, 1'b0, '0);
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_fwft();
        test_simultaneous();
        test_clear();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
